// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types, funct3 size codes and decode helpers for the memory access unit.
package mem_access_pkg;
  typedef enum logic [1:0] {OP_FETCH = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_RSVD = 2'b11} op_kind_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_e;
  typedef enum logic [1:0] {FC_NONE = 2'b00, FC_MISALIGN = 2'b01, FC_TIMEOUT = 2'b10, FC_ILLEGAL = 2'b11} fault_cause_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  // Doubleword and LWU only exist on a 64-bit datapath; stores have no unsigned forms.
  function automatic logic f3_legal(input logic [2:0] f3, input logic st, input logic x64);
    return st ? (!f3[2] && (x64 || f3 != F3_D))
              : (f3 != 3'b111 && (x64 || (f3 != F3_D && f3 != F3_WU)));
  endfunction
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [2:0] a);
    return (f3[1:0] == F3_H[1:0] && a[0]) || (f3[1:0] == F3_W[1:0] && |a[1:0]) ||
           (f3[1:0] == F3_D[1:0] && |a);
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: shifts read data down to its byte lane and sign/zero-extends it;
// also yields the size mask shifted to the lane, used as store byte enables.
module mem_load_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]          rdata,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [2:0]               funct3,
  output logic [XLEN-1:0]          data,
  output logic [XLEN/8-1:0]        lane
);
  localparam int NB = XLEN/8;
  logic [XLEN-1:0] w_sh, w_up;
  logic signed [XLEN-1:0] w_sx;
  logic [6:0] w_pad;
  // Extension works by pushing the field to the top and shifting it back down.
  always_comb begin
    w_sh = rdata >> {offset, 3'b000};
    w_pad = (funct3[1:0] == F3_B[1:0]) ? 7'(XLEN-8) :
            (funct3[1:0] == F3_H[1:0]) ? 7'(XLEN-16) :
            (funct3[1:0] == F3_W[1:0]) ? 7'(XLEN-32) : 7'd0;
    w_up = w_sh << w_pad;
    w_sx = $signed(w_up) >>> w_pad;
    data = funct3[2] ? (w_up >> w_pad) : w_sx;
    lane = ((funct3[1:0] == F3_B[1:0]) ? NB'(1) :
            (funct3[1:0] == F3_H[1:0]) ? NB'(3) :
            (funct3[1:0] == F3_W[1:0]) ? NB'(15) : {NB{1'b1}}) << offset;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: PC/instr/data registers plus fetch/load/store over a req/gnt/rvalid memory.
// Define MEM_TIMEOUT_EN to abort requests that stay in REQ/WAIT for TIMEOUT_CYC cycles.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_kind,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              pc_write,
  input  logic [XLEN-1:0]   pc_next,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   old_pc,
  output logic [31:0]       instr,
  output logic [XLEN-1:0]   data,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB = XLEN/8;
  localparam int OW = $clog2(NB);
  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_REQ  = 2'(S_REQ);
  localparam logic [1:0] ST_WAIT = 2'(S_WAIT);

  if ((XLEN != 32 && XLEN != 64) || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mem_access_unit: XLEN must be 32 or 64 and TIMEOUT_CYC positive");
  end

  logic [1:0] r_state, r_kind, r_cause;
  logic [2:0] r_f3;
  logic [XLEN-1:0] r_addr, r_wdata, r_pc, r_old_pc, r_data;
  logic [31:0] r_instr;
  logic r_done, r_fault;
  logic [XLEN-1:0] w_a, w_ext;
  logic [NB-1:0] w_lane;
  logic [2:0] w_af3;
  logic [1:0] w_nxt;
  logic w_ill, w_mis, w_acc, w_go, w_is_st, w_is_fe, w_fin_st, w_fin_rd, w_to;

  always_comb begin
    w_a = (op_kind == OP_FETCH) ? r_pc : addr;
    w_ill = (op_kind == OP_RSVD) ||
            (op_kind != OP_FETCH && !f3_legal(funct3, op_kind == OP_STORE, XLEN == 64));
    w_mis = (op_kind == OP_FETCH) ? |w_a[1:0] : f3_misaligned(funct3, w_a[2:0]);
    w_acc = r_state == ST_IDLE && op_valid;
    w_go = w_acc && !w_ill && !w_mis;
    w_is_st = r_kind == OP_STORE;
    w_is_fe = r_kind == OP_FETCH;
    w_af3 = w_is_fe ? F3_WU : r_f3;
    w_fin_st = r_state == ST_REQ && mem_gnt && w_is_st;
    w_fin_rd = r_state == ST_WAIT && mem_rvalid;
    w_nxt = w_to ? ST_IDLE :
            (r_state == ST_IDLE) ? (w_go ? ST_REQ : ST_IDLE) :
            (r_state == ST_REQ) ? (mem_gnt ? (w_is_st ? ST_IDLE : ST_WAIT) : ST_REQ) :
            (mem_rvalid ? ST_IDLE : ST_WAIT);
  end

  // Fetches read the 32-bit lane picked by the latched PC, hence the fixed WU decode.
  mem_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (mem_rdata),
    .offset (r_addr[OW-1:0]),
    .funct3 (w_af3),
    .data   (w_ext),
    .lane   (w_lane)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tcnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tcnt <= '0;
    else if (w_acc) r_tcnt <= '0;
    else if (r_state != ST_IDLE) r_tcnt <= r_tcnt + TW'(1);
  end
  assign w_to = r_state != ST_IDLE && r_tcnt == TW'(TIMEOUT_CYC - 1) && !w_fin_st && !w_fin_rd;
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_kind <= 2'(OP_FETCH);
      r_f3 <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_pc <= RESET_PC;
      r_old_pc <= '0;
      r_instr <= NOP_INSTR;
      r_data <= '0;
      r_done <= 1'b0;
      r_fault <= 1'b0;
      r_cause <= 2'(FC_NONE);
    end else begin
      r_state <= w_nxt;
      r_done <= w_fin_st || w_fin_rd;
      r_fault <= (w_acc && (w_ill || w_mis)) || w_to;
      if (pc_write) r_pc <= pc_next;
      if (w_acc && w_ill) r_cause <= 2'(FC_ILLEGAL);
      else if (w_acc && w_mis) r_cause <= 2'(FC_MISALIGN);
      else if (w_to) r_cause <= 2'(FC_TIMEOUT);
      if (w_acc) begin
        r_kind <= op_kind;
        r_f3 <= funct3;
        r_addr <= w_a;
        r_wdata <= wdata;
      end
      if (w_fin_rd && w_is_fe) begin
        r_instr <= w_ext[31:0];
        r_old_pc <= r_addr;
      end
      if (w_fin_rd && !w_is_fe) r_data <= w_ext;
    end
  end

  assign op_ready = r_state == ST_IDLE;
  assign pc = r_pc;
  assign old_pc = r_old_pc;
  assign instr = r_instr;
  assign data = r_data;
  assign done = r_done;
  assign fault = r_fault;
  assign fault_cause = r_cause;
  assign mem_req = r_state == ST_REQ;
  assign mem_we = mem_req && w_is_st;
  assign mem_addr = {r_addr[XLEN-1:OW], OW'(0)};
  assign mem_be = mem_req ? (w_is_st ? w_lane : {NB{1'b1}}) : '0;
  assign mem_wdata = r_wdata << {r_addr[OW-1:0], 3'b000};
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of fetch, load extension, store lanes, faults, stalls and reset.
// Define MEM_TIMEOUT_EN to exercise the timeout abort instead of an indefinite stall.
module tb_mem_access_unit;
  logic clk = 1'b0, reset_n = 1'b0;
  logic op_valid = 1'b0, op_ready;
  logic [1:0] op_kind = 2'b00;
  logic [2:0] funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0, pc_next = '0, pc, old_pc, instr, data;
  logic pc_write = 1'b0, done, fault;
  logic [1:0] fault_cause;
  logic mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;

  mem_access_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
    .funct3(funct3), .addr(addr), .wdata(wdata), .pc_write(pc_write), .pc_next(pc_next),
    .pc(pc), .old_pc(old_pc), .instr(instr), .data(data), .done(done), .fault(fault),
    .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk) pc_write = 1'b1; pc_next = v;
    @(negedge clk) pc_write = 1'b0;
  endtask

  task automatic issue(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk) op_valid = 1'b1; op_kind = k; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk) op_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", op_ready); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h exp 0", pc); end
    checks++; if (old_pc !== 32'h0) begin errors++; $display("FAIL rst_old_pc: got %h exp 0", old_pc); end
    checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr: got %h exp 00000013", instr); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", data); end
    checks++; if ({done, fault, fault_cause, mem_req, mem_we, mem_be} !== 10'b0) begin
      errors++; $display("FAIL rst_ctrl: got %b exp 0", {done, fault, fault_cause, mem_req, mem_we, mem_be}); end
  endtask

  task automatic test_fetch();
    set_pc(32'h100);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL fetch_pc: got %h exp 100", pc); end
    issue(2'b00, 3'b000, 32'h0, 32'h0);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL fetch_req: got req=%b we=%b addr=%h exp 1 0 100", mem_req, mem_we, mem_addr); end
    mem_gnt = 1'b1;
    @(negedge clk) mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0 || op_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL fetch_wait: got req=%b ready=%b done=%b exp 0 0 0", mem_req, op_ready, done); end
    @(negedge clk) mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk) mem_rvalid = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fetch_done: got %b exp 1", done); end
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL fetch_instr: got %h exp 00500093", instr); end
    checks++; if (old_pc !== 32'h100) begin errors++; $display("FAIL fetch_old_pc: got %h exp 100", old_pc); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL fetch_pulse: got done=%b ready=%b exp 0 1", done, op_ready); end
  endtask

  task automatic test_load();
    logic [2:0]  f3s [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0};
    logic [31:0] as  [6] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200, 32'h200};
    logic [31:0] rds [6] = '{32'h8012_3456, 32'h8012_3456, 32'h8001_ABCD, 32'h8001_ABCD, 32'hDEAD_BEEF, 32'h1234_567F};
    logic [31:0] exs [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      issue(2'b01, f3s[i], as[i], 32'h0);
      mem_gnt = 1'b1;
      @(negedge clk) mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rds[i];
      @(negedge clk) mem_rvalid = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL load%0d_done: got %b exp 1", i, done); end
      checks++; if (data !== exs[i]) begin errors++; $display("FAIL load%0d_data: got %h exp %h", i, data, exs[i]); end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s [4] = '{3'd1, 3'd0, 3'd2, 3'd0};
    logic [31:0] as  [4] = '{32'h102, 32'h103, 32'h104, 32'h101};
    logic [31:0] wds [4] = '{32'h0000_BEEF, 32'h0000_00A5, 32'h1234_5678, 32'h0000_003C};
    logic [3:0]  bes [4] = '{4'b1100, 4'b1000, 4'b1111, 4'b0010};
    logic [31:0] ews [4] = '{32'hBEEF_0000, 32'hA500_0000, 32'h1234_5678, 32'h0000_3C00};
    for (int i = 0; i < 4; i++) begin
      issue(2'b10, f3s[i], as[i], wds[i]);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== (as[i] & 32'hFFFF_FFFC)) begin
        errors++; $display("FAIL st%0d_req: got req=%b we=%b addr=%h exp 1 1 %h", i, mem_req, mem_we, mem_addr, as[i] & 32'hFFFF_FFFC); end
      checks++; if (mem_be !== bes[i]) begin errors++; $display("FAIL st%0d_be: got %b exp %b", i, mem_be, bes[i]); end
      checks++; if (mem_wdata !== ews[i]) begin errors++; $display("FAIL st%0d_wdata: got %h exp %h", i, mem_wdata, ews[i]); end
      mem_gnt = 1'b1;
      @(negedge clk) mem_gnt = 1'b0;
      checks++; if (done !== 1'b1 || op_ready !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL st%0d_done: got done=%b ready=%b req=%b exp 1 1 0", i, done, op_ready, mem_req); end
    end
  endtask

  task automatic test_fault();
    logic [1:0]  ks  [6] = '{2'b01, 2'b10, 2'b01, 2'b11, 2'b01, 2'b10};
    logic [2:0]  f3s [6] = '{3'd2, 3'd1, 3'd3, 3'd0, 3'd6, 3'd3};
    logic [31:0] as  [6] = '{32'h101, 32'h101, 32'h100, 32'h100, 32'h100, 32'h100};
    logic [1:0]  cs  [6] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    for (int i = 0; i < 6; i++) begin
      issue(ks[i], f3s[i], as[i], 32'h0);
      checks++; if (fault !== 1'b1 || fault_cause !== cs[i]) begin
        errors++; $display("FAIL flt%0d: got fault=%b cause=%b exp 1 %b", i, fault, fault_cause, cs[i]); end
      checks++; if (mem_req !== 1'b0 || op_ready !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL flt%0d_idle: got req=%b ready=%b done=%b exp 0 1 0", i, mem_req, op_ready, done); end
      @(negedge clk);
      checks++; if (fault !== 1'b0 || fault_cause !== cs[i] || mem_req !== 1'b0) begin
        errors++; $display("FAIL flt%0d_hold: got fault=%b cause=%b req=%b exp 0 %b 0", i, fault, fault_cause, mem_req, cs[i]); end
    end
    set_pc(32'h102);
    issue(2'b00, 3'b000, 32'h0, 32'h0);
    checks++; if (fault !== 1'b1 || fault_cause !== 2'b01 || mem_req !== 1'b0) begin
      errors++; $display("FAIL flt_fetch: got fault=%b cause=%b req=%b exp 1 01 0", fault, fault_cause, mem_req); end
  endtask

  task automatic test_stall();
    issue(2'b01, 3'd2, 32'h300, 32'h0);
    addr = 32'hFFF;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_be !== 4'hF) begin
        errors++; $display("FAIL stall%0d: got req=%b addr=%h be=%b exp 1 300 1111", i, mem_req, mem_addr, mem_be); end
      @(negedge clk);
    end
    checks++; if (fault !== 1'b1 || fault_cause !== 2'b10 || mem_req !== 1'b0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL timeout: got fault=%b cause=%b req=%b ready=%b exp 1 10 0 1", fault, fault_cause, mem_req, op_ready); end
`else
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_be !== 4'hF) begin
        errors++; $display("FAIL stall%0d: got req=%b addr=%h be=%b exp 1 300 1111", i, mem_req, mem_addr, mem_be); end
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk) mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk) mem_rvalid = 1'b0;
    checks++; if (done !== 1'b1 || data !== 32'hCAFE_F00D || fault !== 1'b0) begin
      errors++; $display("FAIL stall_done: got done=%b data=%h fault=%b exp 1 cafef00d 0", done, data, fault); end
`endif
  endtask

  task automatic test_pc_during_fetch();
    set_pc(32'h200);
    issue(2'b00, 3'b000, 32'h0, 32'h0);
    pc_write = 1'b1; pc_next = 32'h204;
    @(negedge clk) pc_write = 1'b0;
    checks++; if (pc !== 32'h204 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL pcw_req: got pc=%h req=%b addr=%h exp 204 1 200", pc, mem_req, mem_addr); end
    mem_gnt = 1'b1;
    @(negedge clk) mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0113;
    @(negedge clk) mem_rvalid = 1'b0;
    checks++; if (done !== 1'b1 || instr !== 32'h00A0_0113 || old_pc !== 32'h200 || pc !== 32'h204) begin
      errors++; $display("FAIL pcw_done: got done=%b instr=%h old_pc=%h pc=%h exp 1 00a00113 200 204", done, instr, old_pc, pc); end
  endtask

  task automatic test_reset_mid();
    issue(2'b01, 3'd2, 32'h400, 32'h0);
    mem_gnt = 1'b1;
    @(negedge clk) mem_gnt = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || pc !== 32'h0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL rstw: got req=%b pc=%h ready=%b exp 0 0 1", mem_req, pc, op_ready); end
    @(negedge clk) reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk) mem_rvalid = 1'b0;
    checks++; if (done !== 1'b0 || data !== 32'h0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL rstw_late: got done=%b data=%h ready=%b exp 0 0 1", done, data, op_ready); end
    issue(2'b01, 3'd2, 32'h400, 32'h0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstr_pre: got %b exp 1", mem_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL rstr: got req=%b ready=%b exp 0 1", mem_req, op_ready); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_fault();
    test_stall();
    test_pc_during_fetch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
